// File: rtl/lupa_reg_scheduler.sv
// LUPA300 SPI register-write scheduler: merges host and auto-exposure writes and issues them
// only inside frame blanking. Optional macro LUPA_REG_COALESCE_EN merges writes by address.
module lupa_reg_scheduler #(
  parameter int QDEPTH        = 4,
  parameter int GUARD_CYC     = 64,
  parameter int MAX_PER_BLANK = 8,
  parameter int TIMEOUT_CYC   = 4096
) (
  input  logic        iCLOCK_80,
  input  logic        iRESET,
  input  logic        Frame_Valid,
  input  logic        host_req,
  input  logic [15:0] host_data,
  output logic        host_ack,
  input  logic        ae_req,
  input  logic [15:0] ae_data,
  output logic        ae_ack,
  output logic        spi_start,
  output logic [15:0] spi_word,
  input  logic        spi_done,
  output logic        blank_open,
  output logic [4:0]  q_level,
  output logic        late_err,
  output logic        tmo_err
);
  localparam int PW = $clog2(QDEPTH);
  localparam int GW = $clog2(GUARD_CYC + 1);
  localparam int IW = $clog2(MAX_PER_BLANK + 1);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GW-1:0] GUARD_MAX = GW'(GUARD_CYC);
  localparam logic [IW-1:0] ISSUE_MAX = IW'(MAX_PER_BLANK);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYC - 1);
  localparam logic [4:0]    LEVEL_MAX = 5'(QDEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT} state_t;
  state_t state_reg, state_next;

  logic          fv_meta_reg, fv_s_reg, fv_d_reg;
  logic          fv_fall, fv_rise;
  logic [GW-1:0] guard_reg;
  logic [IW-1:0] issued_reg;
  logic [TW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [15:0]   mem_reg [QDEPTH];
  logic [PW-1:0] rd_ptr_reg, wr_ptr_reg, wr_idx, merge_idx;
  logic [4:0]    level_reg;
  logic          rr_ae_reg, late_reg, tmo_reg;
  logic          pick_any, pick_ae, accept, push, pop, tmo_hit, merge;
  logic [15:0]   in_word;

  always_ff @(posedge iCLOCK_80 or posedge iRESET) begin
    if (iRESET) begin
      fv_meta_reg <= 1'b0;
      fv_s_reg    <= 1'b0;
      fv_d_reg    <= 1'b0;
    end else begin
      fv_meta_reg <= Frame_Valid;
      fv_s_reg    <= fv_meta_reg;
      fv_d_reg    <= fv_s_reg;
    end
  end

  assign fv_fall    = fv_d_reg & ~fv_s_reg;
  assign fv_rise    = ~fv_d_reg & fv_s_reg;
  assign blank_open = ~fv_s_reg & (guard_reg == GUARD_MAX) & (issued_reg < ISSUE_MAX);

  // Round-robin only matters under contention; the pointer always moves away from the winner.
  always_comb begin
    pick_any = host_req | ae_req;
    pick_ae  = (host_req & ae_req) ? rr_ae_reg : ae_req;
    in_word  = pick_ae ? ae_data : host_data;
  end

`ifdef LUPA_REG_COALESCE_EN
  logic [QDEPTH-1:0] hit;
  for (genvar gi = 0; gi < QDEPTH; gi++) begin : g_match
    logic [PW-1:0] rel;
    assign rel     = PW'(gi) - rd_ptr_reg;
    // The in-flight head must not change under the upload engine.
    assign hit[gi] = (5'(rel) < level_reg)
                   && !((rel == '0) && (state_reg != S_IDLE))
                   && (mem_reg[gi][15:12] == in_word[15:12]);
  end
  always_comb begin
    merge_idx = '0;
    for (int i = QDEPTH - 1; i >= 0; i--) begin
      if (hit[i]) merge_idx = PW'(i);
    end
  end
  assign merge = |hit;
`else
  assign merge     = 1'b0;
  assign merge_idx = '0;
`endif

  assign accept   = pick_any & ((level_reg < LEVEL_MAX) | merge);
  assign push     = accept & ~merge;
  assign wr_idx   = merge ? merge_idx : wr_ptr_reg;
  assign host_ack = accept & ~pick_ae;
  assign ae_ack   = accept & pick_ae;

  always_ff @(posedge iCLOCK_80) begin
    if (accept) mem_reg[wr_idx] <= in_word;
  end

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    pop          = 1'b0;
    tmo_hit      = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if ((level_reg != '0) && blank_open) state_next = S_ISSUE;
      end
      S_ISSUE: begin
        tmo_cnt_next = '0;
        state_next   = S_WAIT;
      end
      S_WAIT: begin
        if (spi_done) begin
          pop        = 1'b1;
          state_next = ((level_reg > 5'd1) && blank_open) ? S_ISSUE : S_IDLE;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          pop        = 1'b1;
          tmo_hit    = 1'b1;
          state_next = S_IDLE;
        end else begin
          tmo_cnt_next = tmo_cnt_reg + TW'(1);
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge iCLOCK_80 or posedge iRESET) begin
    if (iRESET) begin
      state_reg   <= S_IDLE;
      tmo_cnt_reg <= '0;
      guard_reg   <= '0;
      issued_reg  <= '0;
      rd_ptr_reg  <= '0;
      wr_ptr_reg  <= '0;
      level_reg   <= '0;
      rr_ae_reg   <= 1'b0;
      late_reg    <= 1'b0;
      tmo_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      tmo_cnt_reg <= tmo_cnt_next;
      if (fv_fall) guard_reg <= '0;
      else if (!fv_s_reg && (guard_reg != GUARD_MAX)) guard_reg <= guard_reg + GW'(1);
      if (fv_fall) issued_reg <= '0;
      else if (spi_start) issued_reg <= issued_reg + IW'(1);
      if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 5'd1;
        2'b01:   level_reg <= level_reg - 5'd1;
        default: level_reg <= level_reg;
      endcase
      if (accept) rr_ae_reg <= ~pick_ae;
      if ((state_reg != S_IDLE) && fv_rise) late_reg <= 1'b1;
      if (tmo_hit) tmo_reg <= 1'b1;
    end
  end

  assign spi_start = (state_reg == S_ISSUE);
  assign spi_word  = (state_reg == S_IDLE) ? 16'h0000 : mem_reg[rd_ptr_reg];
  assign q_level   = level_reg;
  assign late_err  = late_reg;
  assign tmo_err   = tmo_reg;

endmodule

// File: doc/lupa_reg_scheduler.md
Name: lupa_reg_scheduler

Overview:
- Schedules LUPA300 SPI register writes so they only start inside frame blanking (Frame_Valid low).
- Merges write requests from two sources into one queue: the host/USB command path and the auto-exposure loop.
- Round-robin arbitration between the two sources.
- Sits between the requesters and the SPI upload engine. Issues one 16-bit word (4-bit addr + 12-bit value) per SPI transaction and waits for that transaction's completion before the next.

Parameters:
- QDEPTH, 4: write queue depth in entries; power of 2, 2..16.
- GUARD_CYC, 64: iCLOCK_80 cycles after the synchronized Frame_Valid falling edge before the first write of a window may start.
- MAX_PER_BLANK, 8: maximum SPI writes started per blanking window.
- TIMEOUT_CYC, 4096: cycles to wait for spi_done before the write is abandoned.

Ports:
- iCLOCK_80 in 1: 80 MHz system clock; the only clock.
- iRESET in 1: asynchronous, active-high reset.
- Frame_Valid in 1: sensor frame valid; asynchronous, synchronized internally with 2 flops.
- host_req in 1: host write request; held until host_ack.
- host_data in 16: host write word, [15:12] addr, [11:0] value.
- host_ack out 1: 1-cycle pulse, host word accepted.
- ae_req in 1: auto-exposure write request; held until ae_ack.
- ae_data in 16: auto-exposure write word.
- ae_ack out 1: 1-cycle pulse, auto-exposure word accepted.
- spi_start out 1: 1-cycle pulse to the upload engine.
- spi_word out 16: word for the current transaction; stable from spi_start until spi_done.
- spi_done in 1: 1-cycle pulse, transaction finished.
- blank_open out 1: high while writes are permitted.
- q_level out 5: current queue occupancy.
- late_err out 1: sticky; a transaction was still in flight when Frame_Valid rose.
- tmo_err out 1: sticky; spi_done timeout occurred.

Behaviour:
- Reset values: all outputs 0, queue empty, FSM in IDLE, round-robin pointer favours host, sticky flags clear.
- Synchronizer:
  - fv_s is Frame_Valid after 2 flops.
  - fv_fall = fv_s_d & ~fv_s.
  - fv_rise = ~fv_s_d & fv_s.
- Enqueue:
  - A word is accepted in a cycle when its req=1 and q_level<QDEPTH; the ack pulses in that same cycle.
  - At most one accept per cycle.
  - When both requesters are pending and the queue is not full, grant goes to the pointer's favoured source; the pointer then flips to the other source.
  - Queue full: no ack; requesters hold their req.
  - Enqueue and dequeue in the same cycle are allowed; q_level is unchanged in that case.
- Window counter:
  - Cleared on fv_fall, then increments while fv_s=0, saturating at GUARD_CYC.
  - blank_open = (fv_s==0) & (guard count==GUARD_CYC) & (issued<MAX_PER_BLANK).
  - issued is cleared on fv_fall and increments on each spi_start.
- FSM:
  - IDLE: when q_level!=0 and blank_open, go to ISSUE.
  - ISSUE: one cycle. spi_word = queue head, spi_start=1, load the timeout counter, go to WAIT.
  - WAIT, spi_done=1: pop the head. Go to ISSUE if q_level>1 and blank_open still holds at that cycle; otherwise go to IDLE.
  - WAIT, timeout counter reaches TIMEOUT_CYC: pop (drop) the head, set tmo_err, go to IDLE.
  - WAIT, fv_rise: set late_err; the transaction is never aborted.
- Boundaries:
  - A write never starts while fv_s=1, nor before the guard count completes.
  - The MAX_PER_BLANK-th write completes; no further write starts until the next fv_fall.
  - A Frame_Valid pulse shorter than 2 clocks may be missed. In that case the window simply does not restart.
  - Reset asserted mid-transaction: the queue is flushed and spi_start is not reissued. The upload engine is reset by the same iRESET.
  - Queue pointers wrap modulo QDEPTH; q_level ranges 0..QDEPTH.
- Latency: from fv_fall (synchronized) with a non-empty queue, spi_start asserts GUARD_CYC+2 cycles later.

Optional Feature:
- Macro: LUPA_REG_COALESCE_EN.
- Defined:
  - Before appending, an accepted word is compared by addr [15:12] against all queued entries except the head while the head is in flight.
  - On a match, the matching entry's value is overwritten in place and q_level is unchanged.
  - The ack is given even when the queue is full if a match exists.
  - The latest value per register wins, and queue order is that of the first insertion.
- Not defined: every accepted word is appended; there is no address comparison logic.

Test Plan:
- Basic issue: with Frame_Valid high, host enqueues 0x3123 and ae enqueues 0x5456. Frame_Valid falls → spi_start GUARD_CYC+2 cycles later with spi_word=0x3123. After spi_done, the next spi_start carries 0x5456, and q_level goes 2→1→0.
- Arbitration: host_req and ae_req held high together for 4 accepts → order host, ae, host, ae. Fill 4 entries → queue full, no ack, q_level=4.
- Window limit: MAX_PER_BLANK=2 with 3 entries queued → 2 writes in window 1; the 3rd starts only after the next falling edge plus guard.
- Late frame: Frame_Valid rises during WAIT → late_err=1. The word completes on spi_done and is popped; no further spi_start until the next blanking window.
- Timeout: spi_done never returned → after TIMEOUT_CYC, tmo_err=1, q_level decremented, FSM in IDLE. Reset asserted mid-WAIT → all outputs 0 and q_level=0 on the next cycle.
- Coalesce (LUPA_REG_COALESCE_EN defined): enqueue 0x3001, 0x4002, 0x3FFF before the window opens → q_level=2; issued words are 0x3FFF then 0x4002.
